// File: rtl/sevenseg_pkg.sv
// Shared types, segment patterns and sizing helpers for the 7-segment scan driver.
// Optional leading-zero blanking is enabled with SEVENSEG_LZ_BLANK_EN.
package sevenseg_pkg;

    typedef logic [6:0] seg_pattern_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    localparam seg_pattern_t SEG_BLANK = 7'h7F;
    localparam seg_pattern_t SEG_DASH  = 7'b1111110;

    // Active-low {a,b,c,d,e,f,g} for decimal digits 0..9
    localparam seg_pattern_t SEG_DIGIT [0:9] = '{
        7'b0000001,
        7'b1001111,
        7'b0010010,
        7'b0000110,
        7'b1001100,
        7'b0100100,
        7'b0100000,
        7'b0001111,
        7'b0000000,
        7'b0000100
    };

    function automatic seg_pattern_t seg_decode(input logic [3:0] nib);
        seg_pattern_t pat;
        pat = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (nib == 4'(i)) begin
                pat = SEG_DIGIT[i];
            end
        end
        return pat;
    endfunction

    // ceil(width * log10(2)) in fixed point
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/sevenseg_scan_n_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per cycle,
// with a valid/ready load port and a one-cycle done pulse in COMMIT.
module bin2bcd_seq
    import sevenseg_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int BCD_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [WIDTH-1:0]        load_value,
    output logic                    load_ready,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    done
);

    localparam int BW = 4 * BCD_DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    conv_state_t      state;
    logic [WIDTH-1:0] bin;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bcd_adj;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            load_ready <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        bin        <= load_value;
                        bcd        <= '0;
                        cnt        <= '0;
                        load_ready <= 1'b0;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd <= {bcd_adj[BW-2:0], bin[WIDTH-1]};
                    bin <= bin << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= ST_COMMIT;
                        done  <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state      <= ST_IDLE;
                    load_ready <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_scan_n.sv
// Multi-digit 7-segment scan driver with on-board sequential binary-to-BCD.
// Define SEVENSEG_LZ_BLANK_EN to blank leading zero digits.
module sevenseg_scan_n
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int WIDTH        = 16,
    parameter int REFRESH_BITS = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic [WIDTH-1:0]      load_value,
    output logic                  load_ready,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic [6:0]            seg_n,
    output logic                  overflow
);

    localparam int BCD_DIGITS = bcd_digits(WIDTH);
    localparam int ALL_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW         = 4 * NUM_DIGITS;

    logic [4*BCD_DIGITS-1:0] bcd;
    logic                    done;
    logic [4*ALL_DIGITS-1:0] bcd_ext;
    logic                    hi_nz;

    logic [DW-1:0]           disp;
    logic [REFRESH_BITS-1:0] presc;
    logic [IDX_W-1:0]        idx;

    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   anode_d;
    seg_pattern_t            seg_d;

    bin2bcd_seq #(
        .WIDTH      (WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_conv (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .bcd        (bcd),
        .done       (done)
    );

    // Zero-extend so the display can be wider than the converter
    always_comb begin
        bcd_ext = '0;
        bcd_ext[4*BCD_DIGITS-1:0] = bcd;
        hi_nz = 1'b0;
        for (int i = NUM_DIGITS; i < ALL_DIGITS; i++) begin
            hi_nz = hi_nz | (|bcd_ext[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp     <= '0;
            overflow <= 1'b0;
        end else if (done) begin
            disp     <= bcd_ext[DW-1:0];
            overflow <= hi_nz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= IDX_W'(NUM_DIGITS - 1);
        end else begin
            presc <= presc + 1'b1;
            if (&presc) begin
                idx <= (idx == '0) ? IDX_W'(NUM_DIGITS - 1) : idx - 1'b1;
            end
        end
    end

`ifdef SEVENSEG_LZ_BLANK_EN
    logic lead_zero;

    always_comb begin
        lead_zero = (idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) >= idx && disp[4*i +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
    end
`endif

    always_comb begin
        nib     = '0;
        anode_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib        = disp[4*i +: 4];
                anode_d[i] = 1'b0;
            end
        end
        seg_d = seg_decode(nib);
`ifdef SEVENSEG_LZ_BLANK_EN
        if (lead_zero) begin
            seg_d = SEG_BLANK;
        end
`endif
        if (overflow) begin
            seg_d = SEG_DASH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_n <= '1;
            seg_n   <= SEG_BLANK;
        end else begin
            anode_n <= anode_d;
            seg_n   <= seg_d;
        end
    end

endmodule
